// File: rtl/wb_stage_param.sv
// rtl/wb_stage_param.sv - RV writeback stage: source select, load extract, single-entry output register
// Optional feature macro: WB_INSTRET_EN (64-bit retired-instruction counter on instret)
module wb_stage_param #(
    parameter int              XLEN   = 32,
    parameter int              REG_AW = 5,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_mem_data,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              retire,
    output logic [XLEN-1:0]   wb_pc,
    output logic              exc_misalign,
    output logic              exc_illegal,
    output logic [63:0]       instret
);

    localparam int OB   = $clog2(XLEN / 8);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [OB-1:0]   off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_data;
    logic            ld_mis, ld_ill;
    logic [XLEN-1:0] dec_data;
    logic            dec_wen, dec_mis, dec_ill;
    logic            unused_bits;

    logic              valid_q, valid_d;
    logic              wen_q, wen_d;
    logic              mis_q, mis_d;
    logic              ill_q, ill_d;
    logic              retire_q, retire_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    logic retire_cond, accept;

    assign opc         = in_inst[6:0];
    assign f3          = in_inst[14:12];
    assign off         = in_alu[OB-1:0];
    assign shifted     = in_mem_data >> {off, 3'b000};
    assign unused_bits = ^in_inst[31:15];

    always_comb begin
        ld_data = '0;
        ld_mis  = 1'b0;
        ld_ill  = 1'b0;
        case (f3)
            3'b000: ld_data = XLEN'($signed(shifted[7:0]));
            3'b100: ld_data = XLEN'(shifted[7:0]);
            3'b001: begin
                ld_data = XLEN'($signed(shifted[15:0]));
                ld_mis  = off[0];
            end
            3'b101: begin
                ld_data = XLEN'(shifted[15:0]);
                ld_mis  = off[0];
            end
            3'b010: begin
                ld_data = XLEN'($signed(shifted[31:0]));
                ld_mis  = (off[1:0] != 2'b00);
            end
            3'b110: begin
                if (IS64) begin
                    ld_data = XLEN'(shifted[31:0]);
                    ld_mis  = (off[1:0] != 2'b00);
                end else begin
                    ld_ill = 1'b1;
                end
            end
            3'b011: begin
                if (IS64) begin
                    ld_data = shifted;
                    ld_mis  = (off != '0);
                end else begin
                    ld_ill = 1'b1;
                end
            end
            default: ld_ill = 1'b1;
        endcase
    end

    // An illegal or misaligned load never writes; x0 writes are dropped with zero data.
    always_comb begin
        dec_wen  = 1'b0;
        dec_data = '0;
        dec_mis  = 1'b0;
        dec_ill  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
                dec_wen  = 1'b1;
                dec_data = in_alu;
            end
            OPC_OP_32, OPC_OP_IMM_32: begin
                if (IS64) begin
                    dec_wen  = 1'b1;
                    dec_data = in_alu;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_JAL, OPC_JALR: begin
                dec_wen  = 1'b1;
                dec_data = in_pc + XLEN'(4);
            end
            OPC_LOAD: begin
                dec_wen  = !ld_ill && !ld_mis;
                dec_data = ld_data;
                dec_mis  = ld_mis && !ld_ill;
                dec_ill  = ld_ill;
            end
            OPC_BRANCH, OPC_STORE, OPC_SYSTEM, OPC_FENCE: begin
                dec_wen = 1'b0;
            end
            default: dec_ill = 1'b1;
        endcase
        if (in_inst[11:7] == 5'd0) begin
            dec_wen = 1'b0;
        end
        if (!dec_wen) begin
            dec_data = '0;
        end
    end

    assign retire_cond = valid_q && (!wen_q || rf_ready);
    assign in_ready    = !valid_q || retire_cond;
    assign accept      = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        wen_d    = wen_q;
        mis_d    = mis_q;
        ill_d    = ill_q;
        rd_d     = rd_q;
        data_d   = data_q;
        pc_d     = pc_q;
        retire_d = retire_cond;
        if (accept) begin
            valid_d = 1'b1;
            wen_d   = dec_wen;
            mis_d   = dec_mis;
            ill_d   = dec_ill;
            rd_d    = REG_AW'(in_inst[11:7]);
            data_d  = dec_data;
            pc_d    = in_pc;
        end else if (retire_cond) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            valid_q  <= 1'b0;
            wen_q    <= 1'b0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            pc_q     <= RST_PC;
            retire_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wen_q    <= wen_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
        end
    end

    assign rf_we        = valid_q && wen_q;
    assign rf_waddr     = rd_q;
    assign rf_wdata     = data_q;
    assign fwd_valid    = rf_we;
    assign fwd_rd       = rf_waddr;
    assign fwd_data     = rf_wdata;
    assign retire       = retire_q;
    assign wb_pc        = pc_q;
    assign exc_misalign = valid_q && mis_q;
    assign exc_illegal  = valid_q && ill_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    assign instret_d = retire_q ? instret_q + 64'd1 : instret_q;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// tb/tb_wb_stage_param.sv - directed table, backpressure/reset sequences and random model check for wb_stage_param
module tb_wb_stage_param;

    localparam int XLEN = 32;

    logic        CLK = 1'b0;
    logic        RES;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_inst, in_alu, in_mem_data;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        retire;
    logic [31:0] wb_pc;
    logic        exc_misalign, exc_illegal;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    wb_stage_param #(.XLEN(XLEN), .REG_AW(5), .RST_PC(32'h0)) dut (
        .CLK(CLK), .RES(RES),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_alu(in_alu), .in_mem_data(in_mem_data),
        .rf_ready(rf_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire(retire), .wb_pc(wb_pc),
        .exc_misalign(exc_misalign), .exc_illegal(exc_illegal),
        .instret(instret)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        we;
        logic        chk_data;
        logic [31:0] data;
        logic        mis;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] data;
        logic        mis;
        logic        ill;
    } exp_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int opc, input int f3, input int rd);
        return 32'((f3 << 12) | (rd << 7) | opc);
    endfunction

    // Reference decode, written from the instruction-set rules with plain arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] alu, input logic [31:0] mem);
        exp_t r;
        int op, f3, rd, off, size;
        bit sgn;
        longint unsigned v;
        r   = '0;
        op  = int'(inst[6:0]);
        f3  = int'(inst[14:12]);
        rd  = int'(inst[11:7]);
        off = int'(alu % 4);
        case (op)
            'h37, 'h17, 'h33, 'h13: begin r.wen = 1; r.data = alu; end
            'h6F, 'h67: begin r.wen = 1; r.data = 32'((longint'(pc) + 4) % (64'd1 << 32)); end
            'h63, 'h23, 'h73, 'h0F: r.wen = 0;
            'h03: begin
                size = 0;
                sgn  = 0;
                case (f3)
                    0: begin size = 1; sgn = 1; end
                    4: size = 1;
                    1: begin size = 2; sgn = 1; end
                    5: size = 2;
                    2: begin size = 4; sgn = 1; end
                    default: size = 0;
                endcase
                if (size == 0) r.ill = 1;
                else if (off % size != 0) r.mis = 1;
                else begin
                    v = (longint'(mem) >> (8 * off)) % (64'd1 << (8 * size));
                    if (sgn && v >= (64'd1 << (8 * size - 1)))
                        v = v + (64'd1 << 32) - (64'd1 << (8 * size));
                    r.wen  = 1;
                    r.data = 32'(v);
                end
            end
            default: r.ill = 1;
        endcase
        if (rd == 0) r.wen = 0;
        if (!r.wen) r.data = 0;
        return r;
    endfunction

    vec_t tbl[16];
    int   nv;

    // Random-phase model state
    bit          m_valid, m_wen, m_mis, m_ill, m_ret;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_pc;
    longint      m_cnt;

    int ops[16] = '{'h37, 'h17, 'h33, 'h13, 'h6F, 'h67, 'h03, 'h03,
                    'h03, 'h63, 'h23, 'h73, 'h0F, 'h3B, 'h1B, 'h7F};

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RES = 1'b0; in_valid = 0; in_pc = 0; in_inst = 0; in_alu = 0; in_mem_data = 0; rf_ready = 1;
        @(negedge CLK);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_retire", retire, 0);
        chk("rst_exc", {exc_misalign, exc_illegal}, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_instret", instret, 0);
        chk("rst_in_ready", in_ready, 1);
        #2 RES = 1'b1;

        nv = 0;
        tbl[nv++] = '{enc('h13, 0, 5),  32'h0,        32'h1234,     32'h0,        1, 1, 32'h1234,     0, 0};
        tbl[nv++] = '{enc('h03, 0, 6),  32'h10,       32'h103,      32'h80FF7F01, 1, 1, 32'hFFFFFF80, 0, 0};
        tbl[nv++] = '{enc('h03, 4, 6),  32'h14,       32'h103,      32'h80FF7F01, 1, 1, 32'h00000080, 0, 0};
        tbl[nv++] = '{enc('h03, 1, 6),  32'h18,       32'h102,      32'h80FF7F01, 1, 1, 32'hFFFF80FF, 0, 0};
        tbl[nv++] = '{enc('h03, 5, 6),  32'h1C,       32'h102,      32'h80FF7F01, 1, 1, 32'h000080FF, 0, 0};
        tbl[nv++] = '{enc('h03, 2, 7),  32'h20,       32'h1000,     32'h80FF7F01, 1, 1, 32'h80FF7F01, 0, 0};
        tbl[nv++] = '{enc('h03, 2, 7),  32'h24,       32'h1002,     32'h80FF7F01, 0, 0, 32'h0,        1, 0};
        tbl[nv++] = '{enc('h03, 1, 7),  32'h28,       32'h1001,     32'h80FF7F01, 0, 0, 32'h0,        1, 0};
        tbl[nv++] = '{enc('h03, 3, 7),  32'h2C,       32'h1000,     32'h80FF7F01, 0, 0, 32'h0,        0, 1};
        tbl[nv++] = '{enc('h6F, 0, 1),  32'hFFFFFFFC, 32'h0,        32'h0,        1, 1, 32'h00000000, 0, 0};
        tbl[nv++] = '{enc('h67, 0, 1),  32'h100,      32'h0,        32'h0,        1, 1, 32'h00000104, 0, 0};
        tbl[nv++] = '{enc('h23, 2, 9),  32'h30,       32'h40,       32'h0,        0, 0, 32'h0,        0, 0};
        tbl[nv++] = '{enc('h7F, 0, 9),  32'h34,       32'h40,       32'h0,        0, 0, 32'h0,        0, 1};
        tbl[nv++] = '{enc('h3B, 0, 9),  32'h38,       32'h40,       32'h0,        0, 0, 32'h0,        0, 1};
        tbl[nv++] = '{enc('h13, 0, 0),  32'h3C,       32'h5,        32'h0,        0, 1, 32'h0,        0, 0};
        tbl[nv++] = '{enc('h37, 0, 7),  32'h40,       32'hABCDE000, 32'h0,        1, 1, 32'hABCDE000, 0, 0};

        for (int i = 0; i < nv; i++) begin
            @(posedge CLK); #1;
            in_valid = 1; in_inst = tbl[i].inst; in_pc = tbl[i].pc;
            in_alu = tbl[i].alu; in_mem_data = tbl[i].mem;
            @(posedge CLK); #1;
            in_valid = 0;
            @(negedge CLK);
            chk($sformatf("v%0d_we", i), rf_we, tbl[i].we);
            if (tbl[i].we) chk($sformatf("v%0d_waddr", i), rf_waddr, tbl[i].inst[11:7]);
            if (tbl[i].chk_data) chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].data);
            chk($sformatf("v%0d_fwd", i), {fwd_valid, fwd_rd, fwd_data}, {rf_we, rf_waddr, rf_wdata});
            chk($sformatf("v%0d_mis", i), exc_misalign, tbl[i].mis);
            chk($sformatf("v%0d_ill", i), exc_illegal, tbl[i].ill);
            chk($sformatf("v%0d_pc", i), wb_pc, tbl[i].pc);
            chk($sformatf("v%0d_noret", i), retire, 0);
            @(posedge CLK); #1;
            @(negedge CLK);
            chk($sformatf("v%0d_retire", i), retire, 1);
            chk($sformatf("v%0d_after_we", i), rf_we, 0);
            chk($sformatf("v%0d_after_exc", i), {exc_misalign, exc_illegal}, 0);
        end

        // Backpressure: held entry stable while rf_ready is low, then back-to-back drain.
        @(posedge CLK); #1;
        rf_ready = 0; in_valid = 1; in_inst = enc('h33, 0, 3); in_alu = 1; in_pc = 32'h300;
        @(posedge CLK); #1;
        in_inst = enc('h33, 0, 4); in_alu = 2; in_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd3, 32'd1});
            chk("bp_pc", wb_pc, 32'h300);
            @(posedge CLK); #1;
        end
        rf_ready = 1;
        @(negedge CLK);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_we", {rf_we, rf_waddr}, {1'b1, 5'd3});
        @(posedge CLK); #1;
        in_inst = enc('h23, 2, 0); in_alu = 32'h80; in_pc = 32'h308;
        @(negedge CLK);
        chk("bp_second", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd4, 32'd2});
        chk("bp_second_ready", in_ready, 1);
        chk("bp_retire1", retire, 1);
        @(posedge CLK); #1;
        rf_ready = 0; in_inst = enc('h33, 0, 5); in_alu = 3; in_pc = 32'h30C;
        @(negedge CLK);
        chk("bp_store_we", rf_we, 0);
        chk("bp_store_ready", in_ready, 1);
        chk("bp_retire2", retire, 1);
        @(posedge CLK); #1;
        in_valid = 0; rf_ready = 1;
        @(negedge CLK);
        chk("bp_third", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd5, 32'd3});
        chk("bp_retire_store", retire, 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("bp_drained", rf_we, 0);
        chk("bp_retire3", retire, 1);

        // Reset while an entry is stalled.
        @(posedge CLK); #1;
        rf_ready = 0; in_valid = 1; in_inst = enc('h33, 0, 9); in_alu = 32'h55; in_pc = 32'h200;
        @(posedge CLK); #1;
        in_valid = 0;
        @(negedge CLK);
        chk("rs_pre_we", {rf_we, rf_waddr}, {1'b1, 5'd9});
        #2 RES = 1'b0;
        #1;
        chk("rs_async_out", {rf_we, rf_waddr, rf_wdata, retire}, '0);
        chk("rs_async_pc", wb_pc, 0);
        chk("rs_async_ready", in_ready, 1);
        chk("rs_async_instret", instret, 0);
        @(posedge CLK); #1;
        RES = 1'b1; rf_ready = 1;
        @(negedge CLK);
        chk("rs_no_stale_we", rf_we, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rs_no_retire", retire, 0);

        // Random traffic against the reference model.
        m_valid = 0; m_wen = 0; m_mis = 0; m_ill = 0; m_ret = 0; m_rd = 0; m_data = 0; m_pc = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            bit exp_ready, retiring;
            exp_t e;
            @(posedge CLK); #1;
            in_valid = ($urandom_range(0, 9) < 7);
            rf_ready = ($urandom_range(0, 9) < 7);
            in_inst  = {$urandom} & 32'hFFFF8F80;
            in_inst  = in_inst | 32'(ops[$urandom_range(0, 15)]) | (32'($urandom_range(0, 7)) << 12);
            if ($urandom_range(0, 7) == 0) in_inst[11:7] = 0;
            in_alu      = $urandom;
            in_mem_data = $urandom;
            in_pc       = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            @(negedge CLK);
            exp_ready = !m_valid || !m_wen || rf_ready;
            chk("rnd_in_ready", in_ready, exp_ready);
            chk("rnd_rf_we", rf_we, m_valid && m_wen);
            if (m_valid && m_wen) chk("rnd_write", {rf_waddr, rf_wdata}, {m_rd, m_data});
            chk("rnd_exc", {exc_misalign, exc_illegal}, {m_valid && m_mis, m_valid && m_ill});
            chk("rnd_retire", retire, m_ret);
            if (m_valid) chk("rnd_wb_pc", wb_pc, m_pc);
`ifdef WB_INSTRET_EN
            chk("rnd_instret", instret, m_cnt);
`else
            chk("rnd_instret_off", instret, 0);
`endif
            retiring = m_valid && (!m_wen || rf_ready);
            if (m_ret) m_cnt++;
            m_ret = retiring;
            if (in_valid && exp_ready) begin
                e = ref_dec(in_inst, in_pc, in_alu, in_mem_data);
                m_valid = 1; m_wen = e.wen; m_mis = e.mis; m_ill = e.ill;
                m_rd = in_inst[11:7]; m_data = e.data; m_pc = in_pc;
            end else if (retiring) begin
                m_valid = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
